// File: rtl/mmu.sv
// Word-organised RAM behind a fixed-latency load/store FSM with byte/half/word lanes.
// Optional MMU_MISALIGN_TRAP_EN: adds `misaligned` and suppresses misaligned accesses.
module mmu #(
  parameter int    MEM_WORDS     = 4096,
  parameter int    READ_LATENCY  = 2,
  parameter string MEM_INIT_FILE = ""
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        read_enable,
  input  logic        write_enable,
  input  logic        mem_signed_read,
  input  logic [1:0]  mem_data_width,
  input  logic [31:0] address,
  input  logic [31:0] data_in,
  output logic        mem_ready,
`ifdef MMU_MISALIGN_TRAP_EN
  output logic        misaligned,
`endif
  output logic [31:0] data_out
);

  localparam int AW = $clog2(MEM_WORDS);
  localparam int CW = (READ_LATENCY > 1) ? $clog2(READ_LATENCY) : 1;

  typedef enum logic [1:0] {IDLE, WAIT, DONE} state_e;

  state_e          state_q, state_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic [AW+1:0]   addr_q, addr_d;
  logic [1:0]      width_q, width_d;
  logic            signed_q, signed_d;
  logic            write_q, write_d;
  logic [31:0]     wdata_q, wdata_d;
  logic [31:0]     data_out_q, data_out_d;

  logic            access;
  logic            mis;
  logic            ram_we;
  logic [1:0]      off;
  logic [3:0]      be;
  logic [31:0]     wlanes;
  logic [31:0]     rdata;
  logic [31:0]     rshift;
  logic [31:0]     load_val;
  logic [AW-1:0]   idx;
  logic            unused_addr_hi;

  logic [31:0] mem [MEM_WORDS];

  // Address bits above the RAM depth wrap silently.
  assign unused_addr_hi = ^address[31:AW+2];

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    addr_d   = addr_q;
    width_d  = width_q;
    signed_d = signed_q;
    write_d  = write_q;
    wdata_d  = wdata_q;
    access   = 1'b0;
    case (state_q)
      IDLE: begin
        if (read_enable || write_enable) begin
          addr_d   = address[AW+1:0];
          width_d  = mem_data_width;
          signed_d = mem_signed_read;
          write_d  = write_enable;
          wdata_d  = data_in;
          cnt_d    = CW'(READ_LATENCY - 1);
          state_d  = WAIT;
        end
      end
      WAIT: begin
        if (cnt_q == '0) begin
          access  = 1'b1;
          state_d = DONE;
        end else begin
          cnt_d = cnt_q - CW'(1);
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    off = 2'b00;
    be  = 4'b1111;
    case (width_q)
      2'b00: begin
        off = addr_q[1:0];
        be  = 4'b0001 << off;
      end
      2'b01: begin
        off = {addr_q[1], 1'b0};
        be  = 4'b0011 << off;
      end
      default: begin
        off = 2'b00;
        be  = 4'b1111;
      end
    endcase
`ifdef MMU_MISALIGN_TRAP_EN
    mis = ((width_q == 2'b01) && addr_q[0]) || (width_q[1] && (addr_q[1:0] != 2'b00));
`else
    mis = 1'b0;
`endif
  end

  assign idx    = addr_q[AW+1:2];
  assign ram_we = access && write_q && !mis;
  assign wlanes = wdata_q << {off, 3'b000};
  assign rdata  = mem[idx];
  assign rshift = rdata >> {off, 3'b000};

  always_comb begin
    case (width_q)
      2'b00:   load_val = signed_q ? {{24{rshift[7]}}, rshift[7:0]}
                                   : {24'h0, rshift[7:0]};
      2'b01:   load_val = signed_q ? {{16{rshift[15]}}, rshift[15:0]}
                                   : {16'h0, rshift[15:0]};
      default: load_val = rshift;
    endcase
  end

  // data_out only moves on a completing load (or a trapped access, which clears it).
  always_comb begin
    data_out_d = data_out_q;
    if (access) begin
      if (mis)           data_out_d = 32'h0;
      else if (!write_q) data_out_d = load_val;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q    <= IDLE;
      cnt_q      <= '0;
      addr_q     <= '0;
      width_q    <= 2'b00;
      signed_q   <= 1'b0;
      write_q    <= 1'b0;
      wdata_q    <= 32'h0;
      data_out_q <= 32'h0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      addr_q     <= addr_d;
      width_q    <= width_d;
      signed_q   <= signed_d;
      write_q    <= write_d;
      wdata_q    <= wdata_d;
      data_out_q <= data_out_d;
    end
  end

  // RAM has no reset; a reset during WAIT forces IDLE so ram_we never fires.
  always_ff @(posedge clk) begin
    if (ram_we) begin
      for (int i = 0; i < 4; i++) begin
        if (be[i]) mem[idx][8*i +: 8] <= wlanes[8*i +: 8];
      end
    end
  end

  assign mem_ready = (state_q == DONE);
  assign data_out  = data_out_q;
`ifdef MMU_MISALIGN_TRAP_EN
  assign misaligned = (state_q == DONE) && mis;
`endif

endmodule

// File: tb/tb_mmu.sv
// Directed bench for mmu: latency, lane select/extension, alias, reset-in-WAIT,
// back-to-back with both enables, and the misaligned trap when MMU_MISALIGN_TRAP_EN is set.
module tb_mmu;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        read_enable = 1'b0;
  logic        write_enable = 1'b0;
  logic        mem_signed_read = 1'b0;
  logic [1:0]  mem_data_width = 2'b10;
  logic [31:0] address = 32'h0;
  logic [31:0] data_in = 32'h0;
  logic        mem_ready;
  logic [31:0] data_out;
`ifdef MMU_MISALIGN_TRAP_EN
  logic        misaligned;
`endif

  int checks = 0;
  int errors = 0;

  // scratch outputs of the driver task
  int          lat;
  logic [31:0] rd;
  logic        after;
  logic        mis;

  localparam logic [1:0] W_B = 2'b00, W_H = 2'b01, W_W = 2'b10;

  mmu #(.MEM_WORDS(4096), .READ_LATENCY(2), .MEM_INIT_FILE("")) dut (
    .clk             (clk),
    .reset           (reset),
    .read_enable     (read_enable),
    .write_enable    (write_enable),
    .mem_signed_read (mem_signed_read),
    .mem_data_width  (mem_data_width),
    .address         (address),
    .data_in         (data_in),
    .mem_ready       (mem_ready),
`ifdef MMU_MISALIGN_TRAP_EN
    .misaligned      (misaligned),
`endif
    .data_out        (data_out)
  );

  always #5 clk = ~clk;

  // Issue one request, return edges-until-ready, data_out at ready, ready one cycle later.
  task automatic xact(input logic we, input logic re, input logic sg, input logic [1:0] w,
                      input logic [31:0] a, input logic [31:0] d,
                      output int l, output logic [31:0] r, output logic aft, output logic m);
    @(negedge clk);
    write_enable = we; read_enable = re; mem_signed_read = sg;
    mem_data_width = w; address = a; data_in = d;
    @(posedge clk); #1;
    write_enable = 1'b0; read_enable = 1'b0;
    l = 0;
    do begin
      @(posedge clk); #1;
      l++;
    end while (!mem_ready && l < 20);
    r = data_out;
`ifdef MMU_MISALIGN_TRAP_EN
    m = misaligned;
`else
    m = 1'b0;
`endif
    @(posedge clk); #1;
    aft = mem_ready;
  endtask

  task automatic test_reset();
    repeat (2) @(posedge clk);
    #1;
    checks++; if (mem_ready !== 1'b0) begin errors++; $display("FAIL reset_ready: got %b expected 0", mem_ready); end
    checks++; if (data_out !== 32'h0) begin errors++; $display("FAIL reset_data: got %h expected 00000000", data_out); end
    @(negedge clk); reset = 1'b0;
  endtask

  task automatic test_word();
    xact(1'b1, 1'b0, 1'b0, W_W, 32'h10, 32'hDEADBEEF, lat, rd, after, mis);
    checks++; if (lat !== 2) begin errors++; $display("FAIL word_st_latency: got %0d expected 2", lat); end
    checks++; if (rd !== 32'h0) begin errors++; $display("FAIL word_st_data_kept: got %h expected 00000000", rd); end
    xact(1'b0, 1'b1, 1'b0, W_W, 32'h10, 32'h0, lat, rd, after, mis);
    checks++; if (lat !== 2) begin errors++; $display("FAIL word_ld_latency: got %0d expected 2", lat); end
    checks++; if (rd !== 32'hDEADBEEF) begin errors++; $display("FAIL word_ld_data: got %h expected deadbeef", rd); end
    checks++; if (after !== 1'b0) begin errors++; $display("FAIL word_ready_width: got %b expected 0", after); end
  endtask

  task automatic test_byte();
    xact(1'b1, 1'b0, 1'b0, W_W, 32'h20, 32'h0, lat, rd, after, mis);
    xact(1'b1, 1'b0, 1'b0, W_B, 32'h21, 32'hFFFFFF7F, lat, rd, after, mis);
    xact(1'b1, 1'b0, 1'b0, W_B, 32'h23, 32'h00000080, lat, rd, after, mis);
    xact(1'b0, 1'b1, 1'b0, W_W, 32'h20, 32'h0, lat, rd, after, mis);
    checks++; if (rd !== 32'h80007F00) begin errors++; $display("FAIL byte_word_view: got %h expected 80007f00", rd); end
    xact(1'b0, 1'b1, 1'b1, W_B, 32'h23, 32'h0, lat, rd, after, mis);
    checks++; if (rd !== 32'hFFFFFF80) begin errors++; $display("FAIL byte_signed: got %h expected ffffff80", rd); end
    xact(1'b0, 1'b1, 1'b0, W_B, 32'h23, 32'h0, lat, rd, after, mis);
    checks++; if (rd !== 32'h00000080) begin errors++; $display("FAIL byte_unsigned: got %h expected 00000080", rd); end
    xact(1'b0, 1'b1, 1'b1, W_B, 32'h21, 32'h0, lat, rd, after, mis);
    checks++; if (rd !== 32'h0000007F) begin errors++; $display("FAIL byte_signed_pos: got %h expected 0000007f", rd); end
  endtask

  task automatic test_half();
    xact(1'b1, 1'b0, 1'b0, W_W, 32'h30, 32'h11223344, lat, rd, after, mis);
    xact(1'b1, 1'b0, 1'b0, W_H, 32'h32, 32'h5555ABCD, lat, rd, after, mis);
    xact(1'b0, 1'b1, 1'b1, W_H, 32'h32, 32'h0, lat, rd, after, mis);
    checks++; if (rd !== 32'hFFFFABCD) begin errors++; $display("FAIL half_signed: got %h expected ffffabcd", rd); end
    xact(1'b0, 1'b1, 1'b0, W_H, 32'h30, 32'h0, lat, rd, after, mis);
    checks++; if (rd !== 32'h00003344) begin errors++; $display("FAIL half_low_kept: got %h expected 00003344", rd); end
    xact(1'b0, 1'b1, 1'b0, W_W, 32'h30, 32'h0, lat, rd, after, mis);
    checks++; if (rd !== 32'hABCD3344) begin errors++; $display("FAIL half_word_view: got %h expected abcd3344", rd); end
  endtask

  task automatic test_back_to_back();
    int pulses;
    int first;
    int last;
    int bad_gap;
    int bad_data;
    pulses = 0; first = -1; last = -1; bad_gap = 0; bad_data = 0;
    // data_out currently holds 0xABCD3344 from the previous load
    @(negedge clk);
    write_enable = 1'b1; read_enable = 1'b1; mem_signed_read = 1'b0;
    mem_data_width = W_W; address = 32'h40; data_in = 32'h5A5A5A5A;
    for (int i = 1; i <= 16; i++) begin
      @(posedge clk); #1;
      if (mem_ready) begin
        if (first < 0) first = i;
        else if (i - last != 4) bad_gap++;
        if (data_out !== 32'hABCD3344) bad_data++;
        last = i;
        pulses++;
      end
    end
    write_enable = 1'b0; read_enable = 1'b0;
    checks++; if (pulses !== 4) begin errors++; $display("FAIL b2b_pulses: got %0d expected 4", pulses); end
    checks++; if (first !== 3) begin errors++; $display("FAIL b2b_first: got %0d expected 3", first); end
    checks++; if (bad_gap !== 0) begin errors++; $display("FAIL b2b_gap: got %0d bad gaps expected 0", bad_gap); end
    checks++; if (bad_data !== 0) begin errors++; $display("FAIL b2b_data_kept: got %0d changes expected 0", bad_data); end
    repeat (2) @(posedge clk);
    xact(1'b0, 1'b1, 1'b0, W_W, 32'h40, 32'h0, lat, rd, after, mis);
    checks++; if (rd !== 32'h5A5A5A5A) begin errors++; $display("FAIL b2b_store_done: got %h expected 5a5a5a5a", rd); end
  endtask

  task automatic test_alias();
    xact(1'b1, 1'b0, 1'b0, W_W, 32'h0, 32'hCAFEF00D, lat, rd, after, mis);
    xact(1'b0, 1'b1, 1'b0, W_W, 32'h0000_4000, 32'h0, lat, rd, after, mis);
    checks++; if (rd !== 32'hCAFEF00D) begin errors++; $display("FAIL alias_read: got %h expected cafef00d", rd); end
    xact(1'b1, 1'b0, 1'b0, W_W, 32'h8000_4008, 32'h13579BDF, lat, rd, after, mis);
    xact(1'b0, 1'b1, 1'b0, W_W, 32'h8, 32'h0, lat, rd, after, mis);
    checks++; if (rd !== 32'h13579BDF) begin errors++; $display("FAIL alias_write: got %h expected 13579bdf", rd); end
  endtask

  task automatic test_reset_in_wait();
    int seen;
    seen = 0;
    xact(1'b1, 1'b0, 1'b0, W_W, 32'h50, 32'h11111111, lat, rd, after, mis);
    @(negedge clk);
    write_enable = 1'b1; mem_data_width = W_W; address = 32'h50; data_in = 32'h22222222;
    @(posedge clk); #1;
    write_enable = 1'b0;
    #1 reset = 1'b1;
    #2 reset = 1'b0;
    for (int i = 0; i < 6; i++) begin
      @(posedge clk); #1;
      if (mem_ready) seen++;
    end
    checks++; if (seen !== 0) begin errors++; $display("FAIL rst_wait_no_ready: got %0d pulses expected 0", seen); end
    checks++; if (data_out !== 32'h0) begin errors++; $display("FAIL rst_wait_data_clr: got %h expected 00000000", data_out); end
    xact(1'b0, 1'b1, 1'b0, W_W, 32'h50, 32'h0, lat, rd, after, mis);
    checks++; if (rd !== 32'h11111111) begin errors++; $display("FAIL rst_wait_old_data: got %h expected 11111111", rd); end
  endtask

`ifdef MMU_MISALIGN_TRAP_EN
  task automatic test_misalign();
    xact(1'b0, 1'b1, 1'b0, W_W, 32'h50, 32'h0, lat, rd, after, mis);
    checks++; if (mis !== 1'b0) begin errors++; $display("FAIL mis_aligned_flag: got %b expected 0", mis); end
    xact(1'b0, 1'b1, 1'b0, W_W, 32'h2, 32'h0, lat, rd, after, mis);
    checks++; if (mis !== 1'b1) begin errors++; $display("FAIL mis_word_flag: got %b expected 1", mis); end
    checks++; if (rd !== 32'h0) begin errors++; $display("FAIL mis_word_data: got %h expected 00000000", rd); end
    checks++; if (lat !== 2) begin errors++; $display("FAIL mis_latency: got %0d expected 2", lat); end
    xact(1'b1, 1'b0, 1'b0, W_H, 32'h51, 32'h0000EEEE, lat, rd, after, mis);
    checks++; if (mis !== 1'b1) begin errors++; $display("FAIL mis_half_flag: got %b expected 1", mis); end
    xact(1'b0, 1'b1, 1'b0, W_W, 32'h50, 32'h0, lat, rd, after, mis);
    checks++; if (rd !== 32'h11111111) begin errors++; $display("FAIL mis_no_write: got %h expected 11111111", rd); end
  endtask
`else
  task automatic test_unaligned_forced();
    xact(1'b0, 1'b1, 1'b0, W_W, 32'h52, 32'h0, lat, rd, after, mis);
    checks++; if (rd !== 32'h11111111) begin errors++; $display("FAIL unal_word: got %h expected 11111111", rd); end
    xact(1'b0, 1'b1, 1'b0, W_H, 32'h33, 32'h0, lat, rd, after, mis);
    checks++; if (rd !== 32'h0000ABCD) begin errors++; $display("FAIL unal_half: got %h expected 0000abcd", rd); end
    xact(1'b1, 1'b0, 1'b0, W_H, 32'h51, 32'h0000EEEE, lat, rd, after, mis);
    xact(1'b0, 1'b1, 1'b0, W_W, 32'h50, 32'h0, lat, rd, after, mis);
    checks++; if (rd !== 32'h1111EEEE) begin errors++; $display("FAIL unal_half_store: got %h expected 1111eeee", rd); end
  endtask
`endif

  initial begin
    test_reset();
    test_word();
    test_byte();
    test_half();
    test_back_to_back();
    test_alias();
    test_reset_in_wait();
`ifdef MMU_MISALIGN_TRAP_EN
    test_misalign();
`else
    test_unaligned_forced();
`endif
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
